// File: rtl/instr_mem_loader.sv
// Instruction memory filled by a little-endian byte-stream loader, with a
// combinational fetch port that returns NOP for unloaded or out-of-range words.
module instr_mem_loader #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 1024,
    parameter logic [WIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH-1:0]            addr,
    output logic [WIDTH-1:0]            instr,
    output logic                        misaligned,
    output logic                        out_of_range,
    input  logic                        load_start,
    input  logic                        ld_valid,
    input  logic [7:0]                  ld_data,
    input  logic                        ld_last,
    output logic                        ld_ready,
    output logic                        cpu_stall,
    output logic                        load_done,
    output logic                        load_error,
    output logic [$clog2(DEPTH):0]      words_loaded
);

    localparam int BPW       = WIDTH / 8;
    localparam int ADDR_BITS = $clog2(DEPTH);
    localparam int OFF_BITS  = $clog2(BPW);
    localparam int CNT_BITS  = ADDR_BITS + 1;

    localparam logic [OFF_BITS-1:0] LAST_LANE = OFF_BITS'(BPW - 1);
    localparam logic [CNT_BITS-1:0] LAST_WORD = CNT_BITS'(DEPTH - 1);
    localparam logic [WIDTH:0]      MEM_BYTES = (WIDTH + 1)'(DEPTH * BPW);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

    state_e                state_q, state_d;
    logic                  ld_ready_q, ld_ready_d;
    logic                  cpu_stall_q, cpu_stall_d;
    logic                  load_done_q, load_done_d;
    logic                  load_error_q, load_error_d;
    logic [CNT_BITS-1:0]   words_q, words_d;
    logic [OFF_BITS-1:0]   byte_idx_q, byte_idx_d;
    logic [WIDTH-1:0]      asm_q, asm_d;

    logic                  mem_we;
    logic [ADDR_BITS-1:0]  mem_waddr;
    logic [WIDTH-1:0]      mem_wdata;
    logic [WIDTH-1:0]      mem [DEPTH];

    logic [ADDR_BITS-1:0]  word_idx;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        load_error_d = load_error_q;
        words_d      = words_q;
        byte_idx_d   = byte_idx_q;
        asm_d        = asm_q;
        mem_we       = 1'b0;
        mem_waddr    = words_q[ADDR_BITS-1:0];
        // Lanes above byte_idx are always zero, which gives the zero-fill for a short final word.
        mem_wdata    = asm_q | (WIDTH'(ld_data) << (8 * byte_idx_q));

        case (state_q)
            IDLE, DONE: begin
                if (load_start) begin
                    state_d      = LOAD;
                    load_error_d = 1'b0;
                    words_d      = '0;
                    byte_idx_d   = '0;
                    asm_d        = '0;
                end
            end
            LOAD: begin
                if (ld_valid && ld_ready_q) begin
                    if (byte_idx_q == LAST_LANE || ld_last) begin
                        mem_we     = 1'b1;
                        words_d    = words_q + 1'b1;
                        byte_idx_d = '0;
                        asm_d      = '0;
                        if (ld_last) begin
                            state_d = DONE;
                            if (byte_idx_q != LAST_LANE) load_error_d = 1'b1;
                        end else if (words_q == LAST_WORD) begin
                            state_d      = DONE;
                            load_error_d = 1'b1;
                        end
                    end else begin
                        asm_d      = mem_wdata;
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        ld_ready_d  = (state_d == LOAD);
        cpu_stall_d = (state_d != DONE);
        load_done_d = (state_d == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ld_ready_q   <= 1'b0;
            cpu_stall_q  <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
            words_q      <= '0;
            byte_idx_q   <= '0;
            asm_q        <= '0;
        end else begin
            state_q      <= state_d;
            ld_ready_q   <= ld_ready_d;
            cpu_stall_q  <= cpu_stall_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
            words_q      <= words_d;
            byte_idx_q   <= byte_idx_d;
            asm_q        <= asm_d;
        end
    end

    // NOTE: the array has no reset; words_loaded gating hides whatever it holds.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign word_idx     = addr[ADDR_BITS+OFF_BITS-1:OFF_BITS];
    assign misaligned   = (addr[OFF_BITS-1:0] != '0);
    assign out_of_range = ({1'b0, addr} >= MEM_BYTES);
    assign instr        = (!out_of_range && ({1'b0, word_idx} < words_q)) ? mem[word_idx] : NOP_INSTR;

    assign ld_ready     = ld_ready_q;
    assign cpu_stall    = cpu_stall_q;
    assign load_done    = load_done_q;
    assign load_error   = load_error_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: a default-depth instance for the main
// load scenarios and a DEPTH=4 instance for the overflow case.
module tb_instr_mem_loader;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    int          n_checks = 0;
    int          n_fail   = 0;

    // Main instance, DEPTH=1024
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] instr;
    logic        misaligned, out_of_range;
    logic        load_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
    logic [7:0]  ld_data = '0;
    logic        ld_ready, cpu_stall, load_done, load_error;
    logic [10:0] words_loaded;

    // Small instance, DEPTH=4
    logic        rst_s = 1'b1;
    logic [31:0] addr_s = '0;
    logic [31:0] instr_s;
    logic        misaligned_s, out_of_range_s;
    logic        load_start_s = 1'b0, ld_valid_s = 1'b0, ld_last_s = 1'b0;
    logic [7:0]  ld_data_s = '0;
    logic        ld_ready_s, cpu_stall_s, load_done_s, load_error_s;
    logic [2:0]  words_loaded_s;

    logic [31:0] prog [6] = '{32'h00002083, 32'h00402103, 32'h002081B3,
                              32'h40208233, 32'h0020F2B3, 32'h0020E333};

    always #5 clk = ~clk;

    instr_mem_loader dut (
        .clk(clk), .rst(rst), .addr(addr), .instr(instr),
        .misaligned(misaligned), .out_of_range(out_of_range),
        .load_start(load_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_last(ld_last), .ld_ready(ld_ready), .cpu_stall(cpu_stall),
        .load_done(load_done), .load_error(load_error), .words_loaded(words_loaded)
    );

    instr_mem_loader #(.DEPTH(4)) dut_s (
        .clk(clk), .rst(rst_s), .addr(addr_s), .instr(instr_s),
        .misaligned(misaligned_s), .out_of_range(out_of_range_s),
        .load_start(load_start_s), .ld_valid(ld_valid_s), .ld_data(ld_data_s),
        .ld_last(ld_last_s), .ld_ready(ld_ready_s), .cpu_stall(cpu_stall_s),
        .load_done(load_done_s), .load_error(load_error_s), .words_loaded(words_loaded_s)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        ld_valid = 1'b1;
        ld_data  = b;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, instr, exp);
    endtask

    initial begin
        // Reset state
        tick(); tick();
        rst = 1'b0; rst_s = 1'b0;
        tick();
        fetch("rst_instr_0", 32'h0, NOP);
        fetch("rst_instr_100", 32'h100, NOP);
        check("rst_stall", cpu_stall, 1);
        check("rst_ready", ld_ready, 0);
        check("rst_words", words_loaded, 0);
        check("rst_done", load_done, 0);
        check("rst_error", load_error, 0);

        // Full 6-word image, valid held high
        pulse_start();
        check("load_ready", ld_ready, 1);
        check("load_stall", cpu_stall, 1);
        for (int i = 0; i < 24; i++) begin
            logic [31:0] w;
            w = prog[i/4];
            send_byte(w[8*(i%4) +: 8], i == 23);
            if (i == 3) begin
                check("mid_words", words_loaded, 1);
                fetch("mid_word0_visible", 32'h0, 32'h00002083);
                fetch("mid_word1_nop", 32'h4, NOP);
            end
            if (i == 22) check("latency_not_done", load_done, 0);
        end
        check("img_done", load_done, 1);
        check("img_stall", cpu_stall, 0);
        check("img_error", load_error, 0);
        check("img_words", words_loaded, 6);
        check("img_ready", ld_ready, 0);
        fetch("img_addr8", 32'h8, 32'h002081B3);
        fetch("img_addr18", 32'h18, NOP);
        fetch("img_addr0", 32'h0, 32'h00002083);
        fetch("img_addr14", 32'h14, 32'h0020E333);
        fetch("img_addr6", 32'h6, 32'h00402103);
        check("img_misaligned6", misaligned, 1);
        addr = 32'h4; #1;
        check("img_aligned4", misaligned, 0);

        // Reload hides old image; short final word sets error
        pulse_start();
        check("reload_words", words_loaded, 0);
        check("reload_done", load_done, 0);
        check("reload_stall", cpu_stall, 1);
        fetch("reload_nop", 32'h0, NOP);
        load_start = 1'b1;              // ignored while loading
        send_byte(8'hB3, 1'b0);
        load_start = 1'b0;
        send_byte(8'h81, 1'b1);
        check("part_words", words_loaded, 1);
        check("part_error", load_error, 1);
        check("part_done", load_done, 1);
        fetch("part_word0", 32'h0, 32'h000081B3);
        pulse_start();
        check("clr_error", load_error, 0);
        fetch("clr_nop", 32'h0, NOP);
        ld_last = 1'b1;                 // no ld_valid: must be ignored
        tick();
        ld_last = 1'b0;
        check("lastnovalid_ready", ld_ready, 1);
        check("lastnovalid_words", words_loaded, 0);
        send_byte(8'h93, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hA0, 1'b0);
        send_byte(8'h00, 1'b1);
        fetch("rewrite_word0", 32'h0, 32'h00A00093);
        check("rewrite_error", load_error, 0);

        // DEPTH=4 overflow
        load_start_s = 1'b1; tick(); load_start_s = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i >= 16) check("ovf_ready_low", ld_ready_s, 0);
            ld_valid_s = 1'b1;
            ld_data_s  = 8'(i + 1);
            tick();
            if (i == 15) begin
                check("ovf_done", load_done_s, 1);
                check("ovf_error", load_error_s, 1);
                check("ovf_words", words_loaded_s, 4);
            end
        end
        ld_valid_s = 1'b0;
        check("ovf_words_after", words_loaded_s, 4);
        addr_s = 32'h10; #1;
        check("ovf_oor", out_of_range_s, 1);
        check("ovf_oor_nop", instr_s, NOP);
        addr_s = 32'hC; #1;
        check("ovf_inrange", out_of_range_s, 0);
        check("ovf_word3", instr_s, 32'h100F0E0D);

        // Gapped stream then reset mid-load
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            send_byte(8'(8'h11 + i), 1'b0);
            tick();
        end
        check("gap_words", words_loaded, 1);
        fetch("gap_word0", 32'h0, 32'h14131211);
        fetch("gap_word1_nop", 32'h4, NOP);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_words", words_loaded, 0);
        check("mrst_stall", cpu_stall, 1);
        check("mrst_ready", ld_ready, 0);
        check("mrst_done", load_done, 0);
        fetch("mrst_nop", 32'h0, NOP);

        // Assembly must restart at lane 0 after the discarded partial word
        pulse_start();
        send_byte(8'h93, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h00, 1'b1);
        fetch("post_rst_word0", 32'h0, 32'h00100093);
        check("post_rst_error", load_error, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
